// File: rtl/vector_phase_monitor.sv
// Consumer of the sequencer's one-hot phase vector: encodes the phase, checks
// one-hot validity and phase order, detects stalls and counts completed rounds.
module vector_phase_monitor #(
  parameter int CNT_WIDTH   = 16,
  parameter int DWELL_WIDTH = 8,
  parameter int DWELL_MAX   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [3:0]           vector,
  output logic [1:0]           phase,
  output logic                 phase_vld,
  output logic [CNT_WIDTH-1:0] round_cnt,
  output logic [CNT_WIDTH-1:0] long_cnt,
  output logic                 err_onehot,
  output logic                 err_seq,
  output logic                 err_stall,
  output logic                 err_any
);

  // state | meaning
  // IDLE  | no phase accepted since reset/clr; next one-hot sample is taken as-is
  // TRACK | phase held in 'phase'; order, dwell and round counting active
  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [DWELL_WIDTH-1:0] DWELL_LIM = DWELL_WIDTH'(DWELL_MAX);

  state_t                 state, state_nxt;
  logic [DWELL_WIDTH-1:0] dwell, dwell_nxt;
  logic [1:0]             phase_nxt;
  logic                   phase_vld_nxt;
  logic [CNT_WIDTH-1:0]   round_cnt_nxt, long_cnt_nxt;
  logic                   err_onehot_nxt, err_seq_nxt, err_stall_nxt;

  logic       onehot;
  logic [1:0] enc;
  logic       legal;
  logic       bump_dwell;

  always_comb begin
    enc    = 2'd0;
    onehot = 1'b1;
    case (vector)
      4'b0001: enc = 2'd0;
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  // Legal order: 0->1, 1->2 (long path), 1->3 (short path), 2->3, 3->0.
  always_comb begin
    legal = 1'b0;
    case (phase)
      2'd0: legal = (enc == 2'd1);
      2'd1: legal = (enc == 2'd2) || (enc == 2'd3);
      2'd2: legal = (enc == 2'd3);
      2'd3: legal = (enc == 2'd0);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)         state_nxt = IDLE;
    else if (onehot) state_nxt = TRACK;
  end

  always_comb begin
    phase_nxt      = phase;
    phase_vld_nxt  = phase_vld;
    round_cnt_nxt  = round_cnt;
    long_cnt_nxt   = long_cnt;
    err_onehot_nxt = err_onehot;
    err_seq_nxt    = err_seq;
    err_stall_nxt  = err_stall;
    dwell_nxt      = dwell;
    bump_dwell     = 1'b0;

    if (clr) begin
      phase_nxt      = 2'd0;
      phase_vld_nxt  = 1'b0;
      round_cnt_nxt  = '0;
      long_cnt_nxt   = '0;
      err_onehot_nxt = 1'b0;
      err_seq_nxt    = 1'b0;
      err_stall_nxt  = 1'b0;
      dwell_nxt      = '0;
    end else if (!onehot) begin
      // A garbage sample still counts toward the stall time once tracking.
      err_onehot_nxt = 1'b1;
      bump_dwell     = (state == TRACK);
    end else if (state == IDLE) begin
      phase_nxt     = enc;
      phase_vld_nxt = 1'b1;
      dwell_nxt     = '0;
    end else if (enc == phase) begin
      bump_dwell = 1'b1;
    end else begin
      phase_nxt = enc;
      dwell_nxt = '0;
      if (legal) begin
        if (phase == 2'd3 && enc == 2'd0) round_cnt_nxt = round_cnt + 1'b1;
        if (phase == 2'd1 && enc == 2'd2) long_cnt_nxt  = long_cnt + 1'b1;
      end else begin
        err_seq_nxt = 1'b1;
      end
    end

    if (bump_dwell && dwell != DWELL_LIM) begin
      dwell_nxt = dwell + 1'b1;
      if (dwell == DWELL_LIM - 1'b1) err_stall_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 2'd0;
      phase_vld  <= 1'b0;
      round_cnt  <= '0;
      long_cnt   <= '0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_stall  <= 1'b0;
      dwell      <= '0;
    end else begin
      phase      <= phase_nxt;
      phase_vld  <= phase_vld_nxt;
      round_cnt  <= round_cnt_nxt;
      long_cnt   <= long_cnt_nxt;
      err_onehot <= err_onehot_nxt;
      err_seq    <= err_seq_nxt;
      err_stall  <= err_stall_nxt;
      dwell      <= dwell_nxt;
    end
  end

  assign err_any = err_onehot | err_seq | err_stall;

endmodule

// File: tb/tb_vector_phase_monitor.sv
// Directed bench for vector_phase_monitor with DWELL_MAX=4; expected values
// are hand-computed per scenario.
module tb_vector_phase_monitor;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [3:0]    vector = 4'b0000;
  logic [1:0]    phase;
  logic          phase_vld;
  logic [CW-1:0] round_cnt, long_cnt;
  logic          err_onehot, err_seq, err_stall, err_any;

  int total = 0;
  int bad = 0;

  vector_phase_monitor #(.CNT_WIDTH(CW), .DWELL_WIDTH(8), .DWELL_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vector(vector),
    .phase(phase), .phase_vld(phase_vld), .round_cnt(round_cnt), .long_cnt(long_cnt),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_stall(err_stall), .err_any(err_any)
  );

  always #5 clk = ~clk;

  // {phase, phase_vld, err_onehot, err_seq, err_stall, err_any}
  function automatic logic [6:0] status();
    return {phase, phase_vld, err_onehot, err_seq, err_stall, err_any};
  endfunction

  task automatic step(input logic [3:0] v);
    vector = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(4'b0011);
    clr = 1'b0;
    total++;
    if ({status(), round_cnt, long_cnt} !== {7'b0, 16'd0, 16'd0}) begin
      $display("FAIL clr_all_zero status=%b round=%0d long=%0d want 0000000/0/0",
               status(), round_cnt, long_cnt);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vector = 4'b0100;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({status(), round_cnt, long_cnt} !== {7'b0, 16'd0, 16'd0}) begin
      $display("FAIL reset_state status=%b round=%0d long=%0d want zeros", status(), round_cnt, long_cnt);
      bad++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_long_round();
    logic [3:0] vec [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      step(vec[i]);
      total++;
      if (status() !== {exp[i], 5'b10000}) begin
        $display("FAIL long_round_phase[%0d] status=%b want %b", i, status(), {exp[i], 5'b10000});
        bad++;
      end
    end
    total++;
    if (round_cnt !== 16'd1 || long_cnt !== 16'd1) begin
      $display("FAIL long_round_cnt round=%0d long=%0d want 1/1", round_cnt, long_cnt);
      bad++;
    end
  endtask

  task automatic test_short_path();
    do_clr();
    for (int r = 0; r < 3; r++) begin
      step(4'b0001);
      step(4'b0010);
      step(4'b1000);
    end
    step(4'b0001);
    total++;
    if ({round_cnt, long_cnt, status()} !== {16'd3, 16'd0, 2'd0, 5'b10000}) begin
      $display("FAIL short_path round=%0d long=%0d status=%b want 3/0/0010000", round_cnt, long_cnt, status());
      bad++;
    end
  endtask

  task automatic test_onehot_err();
    do_clr();
    step(4'b0001);
    step(4'b0010);
    step(4'b0011);
    total++;
    if (status() !== 7'b01_1_1_0_0_1) begin
      $display("FAIL onehot_set status=%b want 0111001", status());
      bad++;
    end
    step(4'b0100);
    step(4'b1000);
    total++;
    if ({status(), long_cnt} !== {7'b11_1_1_0_0_1, 16'd1}) begin
      $display("FAIL onehot_sticky status=%b long=%0d want 1111001/1", status(), long_cnt);
      bad++;
    end
    step(4'b0000);
    total++;
    if (err_onehot !== 1'b1 || phase !== 2'd3) begin
      $display("FAIL onehot_zero err_onehot=%b phase=%0d want 1/3", err_onehot, phase);
      bad++;
    end
    do_clr();
  endtask

  task automatic test_seq_err();
    do_clr();
    step(4'b0001);
    step(4'b0100);
    total++;
    if ({status(), round_cnt, long_cnt} !== {7'b10_1_0_1_0_1, 16'd0, 16'd0}) begin
      $display("FAIL seq_err status=%b round=%0d long=%0d want 1010101/0/0", status(), round_cnt, long_cnt);
      bad++;
    end
    step(4'b1000);
    step(4'b0001);
    total++;
    if ({round_cnt, long_cnt, err_seq} !== {16'd1, 16'd0, 1'b1}) begin
      $display("FAIL seq_resync round=%0d long=%0d err_seq=%b want 1/0/1", round_cnt, long_cnt, err_seq);
      bad++;
    end
  endtask

  task automatic test_stall();
    do_clr();
    step(4'b0001);
    for (int i = 1; i <= 5; i++) begin
      step(4'b0010);
      total++;
      if (err_stall !== (i == 5)) begin
        $display("FAIL stall_hold[%0d] err_stall=%b want %b", i, err_stall, (i == 5));
        bad++;
      end
    end
    total++;
    if (err_any !== 1'b1) begin
      $display("FAIL stall_any err_any=%b want 1", err_any);
      bad++;
    end
    do_clr();
    step(4'b0001);
    repeat (4) step(4'b0010);
    step(4'b0100);
    total++;
    if (status() !== 7'b10_1_0_0_0_0) begin
      $display("FAIL stall_edge status=%b want 1010000", status());
      bad++;
    end
  endtask

  task automatic test_async_reset();
    do_clr();
    step(4'b0001);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0011);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({status(), round_cnt, long_cnt} !== {7'b0, 16'd0, 16'd0}) begin
      $display("FAIL async_reset status=%b round=%0d long=%0d want zeros", status(), round_cnt, long_cnt);
      bad++;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(4'b1000);
    total++;
    if (status() !== 7'b11_1_0_0_0_0) begin
      $display("FAIL post_reset_first status=%b want 1110000", status());
      bad++;
    end
  endtask

  initial begin
    test_reset();
    test_long_round();
    test_short_path();
    test_onehot_err();
    test_seq_err();
    test_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
